fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one FIFO write port; power of two, 2..8.
REQ-002 Parameter DATA_W, default 16: requester payload width.
REQ-003 Parameter MAX_BURST, default 8: maximum words one grant may write, 1..256.
REQ-004 Parameter IDLE_TO, default 4: owner-idle cycles before forced release, 1..255.
REQ-005 Derived TAG_W = $clog2(N_REQ); FIFO word width = DATA_W+TAG_W (default 18).
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  N_REQ  bit i: requester i presents a word.
REQ-009 req_data  in  N_REQ*DATA_W  slice i at [i*DATA_W +: DATA_W].
REQ-010 req_last  in  N_REQ  bit i: current word ends requester i's packet.
REQ-011 req_ack  out  N_REQ  one-hot or zero; bit i high = word i accepted this cycle.
REQ-012 fifo_full  in  1  FIFO full flag.
REQ-013 fifo_w_en  out  1  FIFO write enable.
REQ-014 fifo_data  out  DATA_W+TAG_W  {owner tag, payload}; tag in MSBs.
REQ-015 busy  out  1  high while a grant is held.
REQ-016 owner  out  TAG_W  current or most recent grantee index.

Function
REQ-017 FSM states: IDLE, BURST; registered state, owner, rr_ptr, beat_cnt, idle_cnt.
REQ-018 IDLE: scan req_valid from rr_ptr upward, modulo N_REQ; first set bit becomes owner; go to BURST next cycle; no write happens in the IDLE cycle (1-cycle arbitration latency).
REQ-019 IDLE with req_valid == 0: remain in IDLE; owner holds its value.
REQ-020 BURST transfer condition: req_valid[owner] & !fifo_full.
REQ-021 req_ack[owner] and fifo_w_en combinationally equal the transfer condition; all other ack bits 0.
REQ-022 fifo_data combinationally = {owner, req_data slice owner}; value irrelevant when fifo_w_en low.
REQ-023 Each transfer increments beat_cnt (counts 0..MAX_BURST-1).
REQ-024 Burst ends on a transfer with req_last[owner] set, or on the transfer where beat_cnt == MAX_BURST-1, whichever comes first.
REQ-025 Burst end: next state IDLE, rr_ptr <= owner+1 (wraps modulo N_REQ), beat_cnt <= 0.
REQ-026 fifo_full high: no transfer, no ack; beat_cnt, idle_cnt and grant frozen; no timeout while full.
REQ-027 req_valid[owner] low with fifo_full low: idle_cnt increments; any transfer clears idle_cnt.
REQ-028 idle_cnt reaching IDLE_TO: forced release; same actions as REQ-025.
REQ-029 Requests from non-owners during BURST are ignored; no preemption.
REQ-030 busy = (state == BURST).
REQ-031 Never more than one fifo_w_en per cycle; never a write while fifo_full is high.

Reset
REQ-032 rst asserted: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, idle_cnt 0, busy 0, req_ack 0, fifo_w_en 0, immediately and independent of clk.
REQ-033 Reset mid-burst discards the burst; no further write until a new arbitration after rst deasserts.
REQ-034 First arbitration after reset starts the scan at requester 0.

Verification
REQ-035 Req 1 only, 3 words, last on word 3 -> 1 idle cycle, then fifo_data = 0x1xxxx on 3 consecutive writes, busy 1 for 3 cycles, back to IDLE.
REQ-036 All 4 valid continuously, never last, MAX_BURST 8 -> grants 0,1,2,3,0 in order, 8 writes each, one IDLE gap between bursts.
REQ-037 Req 2 bursting, fifo_full high 5 cycles after word 2 -> no ack or write for 5 cycles, no timeout, resume at word 3, total burst still capped at 8.
REQ-038 Req 0 valid 2 words then drops valid, IDLE_TO 4 -> forced release after 4 idle cycles; next grant goes to requester 1 if valid.
REQ-039 rst pulse during word 4 of a burst -> fifo_w_en 0 and busy 0 immediately; next grant after release is requester 0.
REQ-040 Random valid/last/full stimulus, 10k cycles -> scoreboard: per-requester word order preserved, tag correct, no write while full, at most one ack bit per cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting N_REQ requesters bursts on one FIFO write port.
// Write data is tagged with the owner index in the MSBs.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int IDLE_TO   = 4,
  localparam int TAG_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ack,
  input  logic                      fifo_full,
  output logic                      fifo_w_en,
  output logic [DATA_W+TAG_W-1:0]   fifo_data,
  output logic                      busy,
  output logic [TAG_W-1:0]          owner
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int IW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [TAG_W-1:0] rr_ptr;
  logic [BW-1:0]    beat_cnt;
  logic [IW-1:0]    idle_cnt;

  logic             found;
  logic [TAG_W-1:0] pick;
  logic             xfer;
  logic             stall;
  logic             rel;

  // Scan req_valid from rr_ptr upward, wrapping; first hit wins.
  always_comb begin
    logic [TAG_W-1:0] idx;
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + TAG_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Transfer, owner-idle detection and burst release.
  always_comb begin
    busy  = (state == BURST);
    xfer  = busy & req_valid[owner] & ~fifo_full;
    stall = busy & ~req_valid[owner] & ~fifo_full;
    rel   = (xfer & (req_last[owner] |
                     (beat_cnt == BW'(MAX_BURST - 1)))) |
            (stall & (idle_cnt == IW'(IDLE_TO - 1)));
  end

  // Write port and acknowledge driven straight from the transfer.
  always_comb begin
    fifo_w_en = xfer;
    req_ack   = '0;
    if (xfer)
      req_ack[owner] = 1'b1;
    fifo_data = {owner, req_data[owner*DATA_W +: DATA_W]};
  end

  // Grant FSM: arbitrate in IDLE, stream words in BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= BURST;
            owner    <= pick;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        BURST: begin
          if (rel) begin
            state    <= IDLE;
            rr_ptr   <= owner + TAG_W'(1);
            beat_cnt <= '0;
            idle_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + BW'(1);
            idle_cnt <= '0;
          end else if (stall) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed bursts plus random traffic
// checked against a per-cycle behavioural model of the grant rules.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MB  = 8;
  localparam int ITO = 4;
  localparam int TW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ack;
  logic            fifo_full = 1'b0;
  logic            fifo_w_en;
  logic [DW+TW-1:0] fifo_data;
  logic            busy;
  logic [TW-1:0]   owner;

  fifo_wr_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .IDLE_TO(ITO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack),
    .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    logic          we;
    logic [DW+TW-1:0] data;
    logic [N-1:0]  ack;
    logic          bz;
    logic [TW-1:0] own;
  } rec_t;

  word_t src[N][$];
  rec_t  exp_q[$];
  logic [N-1:0] en = '1;

  int n_vec = 0;
  int n_err = 0;

  // model state: current grant, next scan start, words and idle cycles
  int m_busy = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_words = 0;
  int m_idle = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_release();
    m_busy  = 0;
    m_ptr   = (m_own + 1) % N;
    m_words = 0;
    m_idle  = 0;
  endtask

  // One clock: drive inputs, predict outputs, queue the prediction.
  task automatic cycle(input logic full_i, input logic rst_i);
    rec_t r;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [N*DW-1:0] d;
    logic rise;
    @(posedge clk);
    #1;
    rise = rst_i && !rst;
    for (int i = 0; i < N; i++) begin
      v[i] = (src[i].size() > 0) && en[i];
      l[i] = (src[i].size() > 0) ? src[i][0].l : 1'($urandom);
      d[i*DW +: DW] = (src[i].size() > 0) ? src[i][0].d : DW'($urandom);
    end
    rst       = rst_i;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = full_i;
    r.we = 1'b0;
    r.data = '0;
    r.ack = '0;
    r.bz = 1'b0;
    r.own = '0;
    if (rst_i) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_words = 0; m_idle = 0;
    end else begin
      r.bz  = (m_busy != 0);
      r.own = TW'(m_own);
      if (m_busy == 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_busy == 0 && v[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N;
            m_busy = 1;
            m_words = 0;
            m_idle = 0;
          end
        end
      end else if (v[m_own] && !full_i) begin
        word_t w;
        w = src[m_own].pop_front();
        r.we = 1'b1;
        r.ack[m_own] = 1'b1;
        r.data = {TW'(m_own), w.d};
        m_words++;
        m_idle = 0;
        if (w.l || m_words == MB) m_release();
      end else if (!full_i) begin
        m_idle++;
        if (m_idle == ITO) m_release();
      end
    end
    exp_q.push_back(r);
    if (rise) begin
      #1;
      chk("rst_immediate_wen", 32'(fifo_w_en), 32'd0);
      chk("rst_immediate_busy", 32'(busy), 32'd0);
    end
  endtask

  // Monitor: compare DUT outputs with the queued prediction mid-cycle.
  always @(negedge clk) begin
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("w_en", 32'(fifo_w_en), 32'(r.we));
      chk("ack", 32'(req_ack), 32'(r.ack));
      chk("busy", 32'(busy), 32'(r.bz));
      chk("owner", 32'(owner), 32'(r.own));
      if (r.we)
        chk("fifo_data", 32'(fifo_data), 32'(r.data));
      if (fifo_full)
        chk("write_while_full", 32'(fifo_w_en), 32'd0);
    end
  end

  task automatic push_words(input int i, input int n, input int last_at);
    word_t w;
    for (int k = 1; k <= n; k++) begin
      w.d = DW'($urandom);
      w.l = (k == last_at);
      src[i].push_back(w);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) src[i].delete();
    en = '1;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wen", 32'(fifo_w_en), 32'd0);
    chk("reset_ack", 32'(req_ack), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);

    // single requester, three-word packet
    do_reset();
    push_words(1, 3, 3);
    for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0);
    chk("drain_req1", 32'(src[1].size()), 32'd0);

    // all requesters saturated, bursts capped
    do_reset();
    for (int i = 0; i < N; i++) push_words(i, 16, 0);
    for (int c = 0; c < 45; c++) cycle(1'b0, 1'b0);
    chk("rr_req0_left", 32'(src[0].size()), 32'd0);
    chk("rr_req3_left", 32'(src[3].size()), 32'd8);

    // full stall mid-burst, no timeout, cap still applies
    do_reset();
    push_words(2, 12, 0);
    for (int c = 0; c < 25; c++) cycle(c >= 3 && c <= 7, 1'b0);
    chk("drain_req2", 32'(src[2].size()), 32'd0);

    // owner goes quiet: forced release, then requester 1
    do_reset();
    push_words(0, 2, 0);
    push_words(1, 2, 2);
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0);
    chk("drain_req1_after_to", 32'(src[1].size()), 32'd0);

    // reset in the middle of a burst
    do_reset();
    for (int i = 0; i < N; i++) push_words(i, 6, 0);
    begin
      int fired = 0;
      for (int c = 0; c < 30; c++) begin
        if (fired == 0 && m_busy != 0 && m_words == 3 && m_own == 1) begin
          fired = 1;
          cycle(1'b0, 1'b1);
          cycle(1'b0, 1'b1);
        end else begin
          cycle(1'b0, 1'b0);
        end
      end
      chk("mid_reset_fired", 32'(fired), 32'd1);
    end

    // random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() < 3 && $urandom_range(3) == 0)
          push_words(i, 1, ($urandom_range(3) == 0) ? 1 : 0);
        en[i] = ($urandom_range(7) != 0);
      end
      cycle($urandom_range(4) == 0, 1'b0);
    end

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
